// File: rtl/ce_tx_stream_arb.sv
// ce_tx_stream_arb: packet-level round-robin arbiter that merges NUM_CH AXI-Stream TX sources
// onto one PCIe SS TX stream through a 2-entry output skid. Optional macro: CE_TX_ARB_CH0_PRIO_EN.
module ce_tx_stream_arb #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 10,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CH_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         fim_clk,
    input  logic                         fim_rst_n,
    input  logic [NUM_CH-1:0]            s_tvalid,
    output logic [NUM_CH-1:0]            s_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH*KEEP_WIDTH-1:0] s_tkeep,
    input  logic [NUM_CH*USER_WIDTH-1:0] s_tuser,
    input  logic [NUM_CH-1:0]            s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [KEEP_WIDTH-1:0]        m_tkeep,
    output logic [USER_WIDTH-1:0]        m_tuser,
    output logic                         m_tlast,
    output logic [CH_IDX_W-1:0]          grant_idx,
    output logic                         pkt_active
);

    // Handshake: a beat moves on any port exactly when valid && ready are both high at the rising
    // edge; m_t* stay stable while m_tvalid && !m_tready, and a source may drop tvalid mid-packet.

    localparam int                  BEAT_W   = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
    localparam logic [CH_IDX_W:0]   NUM_CH_W = (CH_IDX_W + 1)'(NUM_CH);
    localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(NUM_CH - 1);

`ifdef CE_TX_ARB_CH0_PRIO_EN
    localparam bit CH0_PRIO = 1'b1;
`else
    localparam bit CH0_PRIO = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CH_IDX_W-1:0] rr_ptr;
    logic [CH_IDX_W-1:0] winner;
    logic                winner_vld;
    logic [CH_IDX_W:0]   scan_sum;
    logic [CH_IDX_W-1:0] scan_idx;
    logic [CH_IDX_W-1:0] sel_ch;
    logic                sel_vld;
    logic                space_ok;
    logic                accept;
    logic                pop;
    logic                in_last;
    logic [1:0]          cnt;
    logic [1:0]          cnt_nxt;
    logic [BEAT_W-1:0]   in_beat;
    logic [BEAT_W-1:0]   ent0;
    logic [BEAT_W-1:0]   ent1;

    // Winner search starts at rr_ptr and wraps; with channel-0 priority, ch0 is taken first
    // and excluded from the rotating scan.
    always_comb begin : p_winner
        winner     = '0;
        winner_vld = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        if (CH0_PRIO && s_tvalid[0]) begin
            winner_vld = 1'b1;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            scan_sum = {1'b0, rr_ptr} + (CH_IDX_W + 1)'(k);
            if (scan_sum >= NUM_CH_W) begin
                scan_sum = scan_sum - NUM_CH_W;
            end
            scan_idx = scan_sum[CH_IDX_W-1:0];
            if (!winner_vld && s_tvalid[scan_idx] && !(CH0_PRIO && scan_idx == '0)) begin
                winner     = scan_idx;
                winner_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge fim_clk or negedge fim_rst_n) begin : p_state_reg
        if (!fim_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : p_next_state
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept && !in_last) state_nxt = ST_LOCKED;
            ST_LOCKED: if (accept && in_last)  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // While locked, the owning channel keeps the grant even through its own bubbles.
    always_comb begin : p_outputs
        sel_ch     = winner;
        sel_vld    = winner_vld;
        pkt_active = 1'b0;
        s_tready   = '0;
        if (state == ST_LOCKED) begin
            sel_ch     = grant_idx;
            sel_vld    = 1'b1;
            pkt_active = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            s_tready[i] = space_ok && sel_vld && (sel_ch == CH_IDX_W'(i));
        end
    end

    always_comb begin : p_in_mux
        in_beat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == CH_IDX_W'(i)) begin
                in_beat = {s_tlast[i], s_tuser[i*USER_WIDTH +: USER_WIDTH],
                           s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH], s_tdata[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    assign in_last = in_beat[BEAT_W-1];
    assign accept  = space_ok && sel_vld && s_tvalid[sel_ch];
    assign pop     = m_tvalid && m_tready;
    assign cnt_nxt = cnt + {1'b0, accept} - {1'b0, pop};

    always_ff @(posedge fim_clk or negedge fim_rst_n) begin : p_ctrl
        if (!fim_rst_n) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            cnt       <= 2'd0;
            space_ok  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            space_ok <= (cnt_nxt != 2'd2);
            if (accept && state == ST_IDLE) begin
                grant_idx <= winner;
                if (!(CH0_PRIO && winner == '0)) begin
                    rr_ptr <= (winner == LAST_CH) ? '0 : winner + CH_IDX_W'(1);
                end
            end
        end
    end

    // ent0 always drives the output; ent1 only holds a beat while the output is stalled.
    always_ff @(posedge fim_clk or negedge fim_rst_n) begin : p_skid
        if (!fim_rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= in_beat;
                    else             ent1 <= in_beat;
                end
                2'b01: begin
                    if (cnt == 2'd2) ent0 <= ent1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        ent0 <= in_beat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_tvalid = (cnt != 2'd0);
    assign {m_tlast, m_tuser, m_tkeep, m_tdata} = ent0;

endmodule
